// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants shared by the encoder and the program loader:
// opcodes, R-type functs, operation selects, field positions and loader states.
package mips_isa_pkg;

  // Primary opcodes
  localparam logic [5:0] OPC_RTYPE = 6'd0;
  localparam logic [5:0] OPC_J     = 6'd2;
  localparam logic [5:0] OPC_JAL   = 6'd3;
  localparam logic [5:0] OPC_BEQ   = 6'd4;
  localparam logic [5:0] OPC_BNE   = 6'd5;
  localparam logic [5:0] OPC_ADDI  = 6'd8;
  localparam logic [5:0] OPC_SLTI  = 6'd9;
  localparam logic [5:0] OPC_SLTIU = 6'd10;
  localparam logic [5:0] OPC_ANDI  = 6'd12;
  localparam logic [5:0] OPC_ORI   = 6'd13;
  localparam logic [5:0] OPC_XORI  = 6'd14;
  localparam logic [5:0] OPC_LUI   = 6'd15;
  localparam logic [5:0] OPC_LW    = 6'd35;
  localparam logic [5:0] OPC_SW    = 6'd43;

  // R-type funct codes
  localparam logic [5:0] FN_SLL  = 6'd0;
  localparam logic [5:0] FN_SRL  = 6'd2;
  localparam logic [5:0] FN_SRA  = 6'd3;
  localparam logic [5:0] FN_SLLV = 6'd4;
  localparam logic [5:0] FN_SRLV = 6'd6;
  localparam logic [5:0] FN_SRAV = 6'd7;
  localparam logic [5:0] FN_JR   = 6'd8;
  localparam logic [5:0] FN_ADD  = 6'd32;
  localparam logic [5:0] FN_SUB  = 6'd34;
  localparam logic [5:0] FN_AND  = 6'd36;
  localparam logic [5:0] FN_OR   = 6'd37;
  localparam logic [5:0] FN_XOR  = 6'd38;
  localparam logic [5:0] FN_NOR  = 6'd39;
  localparam logic [5:0] FN_SLT  = 6'd42;
  localparam logic [5:0] FN_SLTU = 6'd43;

  // Operation select; values 28..31 are not defined and are rejected
  typedef enum logic [4:0] {
    OP_SLL, OP_SRL, OP_SRA, OP_SLLV, OP_SRLV, OP_SRAV, OP_JR,
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLT, OP_SLTU,
    OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI,
    OP_XORI, OP_LUI, OP_LW, OP_SW,
    OP_J, OP_JAL
  } op_sel_e;

  // Instruction field bit positions
  localparam int OPC_HI    = 31;
  localparam int OPC_LO    = 26;
  localparam int RS_HI     = 25;
  localparam int RS_LO     = 21;
  localparam int RT_HI     = 20;
  localparam int RT_LO     = 16;
  localparam int RD_HI     = 15;
  localparam int RD_LO     = 11;
  localparam int SHAMT_HI  = 10;
  localparam int SHAMT_LO  = 6;
  localparam int FUNCT_HI  = 5;
  localparam int FUNCT_LO  = 0;
  localparam int IMM_HI    = 15;
  localparam int IMM_LO    = 0;
  localparam int TARGET_HI = 25;
  localparam int TARGET_LO = 0;

  // Loader FSM states
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_ERROR} load_state_e;

  // funct code for an R-type select (0 for anything else)
  function automatic logic [5:0] r_funct(input op_sel_e op);
    logic [5:0] fn;
    case (op)
      OP_SLL:  fn = FN_SLL;
      OP_SRL:  fn = FN_SRL;
      OP_SRA:  fn = FN_SRA;
      OP_SLLV: fn = FN_SLLV;
      OP_SRLV: fn = FN_SRLV;
      OP_SRAV: fn = FN_SRAV;
      OP_JR:   fn = FN_JR;
      OP_ADD:  fn = FN_ADD;
      OP_SUB:  fn = FN_SUB;
      OP_AND:  fn = FN_AND;
      OP_OR:   fn = FN_OR;
      OP_XOR:  fn = FN_XOR;
      OP_NOR:  fn = FN_NOR;
      OP_SLT:  fn = FN_SLT;
      OP_SLTU: fn = FN_SLTU;
      default: fn = 6'd0;
    endcase
    return fn;
  endfunction

  // Primary opcode for an I- or J-type select (0 for anything else)
  function automatic logic [5:0] ij_opcode(input op_sel_e op);
    logic [5:0] opc;
    case (op)
      OP_BEQ:   opc = OPC_BEQ;
      OP_BNE:   opc = OPC_BNE;
      OP_ADDI:  opc = OPC_ADDI;
      OP_SLTI:  opc = OPC_SLTI;
      OP_SLTIU: opc = OPC_SLTIU;
      OP_ANDI:  opc = OPC_ANDI;
      OP_ORI:   opc = OPC_ORI;
      OP_XORI:  opc = OPC_XORI;
      OP_LUI:   opc = OPC_LUI;
      OP_LW:    opc = OPC_LW;
      OP_SW:    opc = OPC_SW;
      OP_J:     opc = OPC_J;
      OP_JAL:   opc = OPC_JAL;
      default:  opc = OPC_RTYPE;
    endcase
    return opc;
  endfunction

endpackage

// File: rtl/instr_encoder.sv
// Combinational MIPS instruction encoder: operation select plus fields in,
// 32-bit instruction word out. Fields an instruction does not use are zeroed.
module instr_encoder
  import mips_isa_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        valid
);

  op_sel_e op_e;
  assign op_e = op_sel_e'(op);

  // Pack only the fields each instruction class actually uses
  always_comb begin
    word  = '0;
    valid = 1'b1;
    case (op_e)
      OP_SLL, OP_SRL, OP_SRA: begin
        // constant shifts: rs is forced to zero
        word[RT_HI:RT_LO]       = rt;
        word[RD_HI:RD_LO]       = rd;
        word[SHAMT_HI:SHAMT_LO] = shamt;
        word[FUNCT_HI:FUNCT_LO] = r_funct(op_e);
      end
      OP_JR: begin
        word[RS_HI:RS_LO]       = rs;
        word[FUNCT_HI:FUNCT_LO] = r_funct(op_e);
      end
      OP_SLLV, OP_SRLV, OP_SRAV, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SLT, OP_SLTU: begin
        // shamt is forced to zero
        word[RS_HI:RS_LO]       = rs;
        word[RT_HI:RT_LO]       = rt;
        word[RD_HI:RD_LO]       = rd;
        word[FUNCT_HI:FUNCT_LO] = r_funct(op_e);
      end
      OP_LUI: begin
        word[OPC_HI:OPC_LO]     = ij_opcode(op_e);
        word[RT_HI:RT_LO]       = rt;
        word[IMM_HI:IMM_LO]     = imm;
      end
      OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI,
      OP_XORI, OP_LW, OP_SW: begin
        word[OPC_HI:OPC_LO]     = ij_opcode(op_e);
        word[RS_HI:RS_LO]       = rs;
        word[RT_HI:RT_LO]       = rt;
        word[IMM_HI:IMM_LO]     = imm;
      end
      OP_J, OP_JAL: begin
        word[OPC_HI:OPC_LO]         = ij_opcode(op_e);
        word[TARGET_HI:TARGET_LO]   = target;
      end
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_loader.sv
// Sequential program loader: encodes incoming instruction fields and writes
// them to instruction memory through a one-entry buffer, holding the CPU
// while a load is in progress.
module instr_loader
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  err_index,
  output logic              cpu_hold
);

  load_state_e       state_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [CNT_W-1:0]  remaining_reg;
  logic [CNT_W-1:0]  accepted_reg;
  logic [CNT_W-1:0]  count_reg;
  logic              full_reg;
  logic [31:0]       word_reg;
  logic              done_reg;
  logic              err_reg;
  logic [CNT_W-1:0]  err_index_reg;

  logic [31:0] enc_word;
  logic        enc_valid;
  logic        accept;
  logic        ack;

  instr_encoder u_encoder (
    .op     (in_op),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .shamt  (in_shamt),
    .imm    (in_imm),
    .target (in_target),
    .word   (enc_word),
    .valid  (enc_valid)
  );

  // Accept when the buffer is free or being emptied this cycle, and words remain to fetch
  assign in_ready = (state_reg == ST_LOAD) && (accepted_reg != count_reg) &&
                    (!full_reg || mem_ack);
  assign accept   = in_valid && in_ready;
  assign ack      = full_reg && mem_ack;

  assign mem_we    = full_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = word_reg;
  assign busy      = (state_reg == ST_LOAD) || (state_reg == ST_DRAIN);
  assign cpu_hold  = (state_reg != ST_IDLE);
  assign done      = done_reg;
  assign err       = err_reg;
  assign err_index = err_index_reg;

  // Loader FSM, write-buffer and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      accepted_reg  <= '0;
      count_reg     <= '0;
      full_reg      <= 1'b0;
      word_reg      <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      err_index_reg <= '0;
    end else begin
      done_reg <= 1'b0;

      if (ack) begin
        addr_reg      <= addr_reg + ADDR_W'(1);
        remaining_reg <= remaining_reg - CNT_W'(1);
      end

      // a simultaneous accept and ack simply replaces the buffered word
      if (accept && enc_valid) begin
        full_reg <= 1'b1;
        word_reg <= enc_word;
      end else if (ack) begin
        full_reg <= 1'b0;
      end

      if (accept) begin
        accepted_reg <= accepted_reg + CNT_W'(1);
      end

      case (state_reg)
        ST_IDLE, ST_ERROR: begin
          if (start) begin
            addr_reg      <= base_addr;
            remaining_reg <= word_count;
            count_reg     <= word_count;
            accepted_reg  <= '0;
            err_reg       <= 1'b0;
            err_index_reg <= '0;
            if (word_count == '0) begin
              done_reg  <= 1'b1;
              state_reg <= ST_IDLE;
            end else begin
              state_reg <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (accept && !enc_valid) begin
            err_reg       <= 1'b1;
            err_index_reg <= accepted_reg;
            state_reg     <= ST_DRAIN;
          end else if (ack && remaining_reg == CNT_W'(1)) begin
            done_reg  <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (!full_reg) begin
            state_reg <= ST_ERROR;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: expected memory writes are queued
// when a word is accepted and compared when the write is acknowledged.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] word_count = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_op = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic        busy, done, err, cpu_hold;
  logic [10:0] err_index;

  typedef struct {
    logic [9:0]  a;
    logic [31:0] d;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [9:0]  exp_addr = '0;
  int          tests = 0;
  int          fails = 0;
  int          writes = 0;
  int          done_count = 0;
  int          cyc = 0;

  instr_loader #(.ADDR_W(10), .CNT_W(11)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .busy(busy), .done(done), .err(err),
    .err_index(err_index), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Write monitor: every acknowledged write is checked against the scoreboard
  always @(negedge clk) begin
    if (rst_n && mem_we && mem_ack) begin
      writes++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write addr=%h data=%h required=no write", mem_addr, mem_wdata);
      end else begin
        e = sb.pop_front();
        if (mem_addr !== e.a || mem_wdata !== e.d) begin
          fails++;
          $display("FAIL write addr=%h data=%h required addr=%h data=%h", mem_addr, mem_wdata, e.a, e.d);
        end else begin
          $display("[TB] write addr=%h data=%h", mem_addr, mem_wdata);
        end
      end
    end
    if (rst_n && done) done_count++;
  end

  task automatic do_start(input logic [9:0] b, input logic [10:0] c);
    start = 1'b1; base_addr = b; word_count = c; exp_addr = b;
    @(posedge clk); #1;
    start = 1'b0;
    $display("[TB] start base=%h count=%0d", b, c);
  endtask

  // Present one instruction; expected word queued at acceptance if valid
  task automatic send(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                      input logic [25:0] tgt, input logic exp_ok, input logic [31:0] exp_word,
                      output int acc_cyc);
    int n;
    exp_t x;
    in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_imm = imm; in_target = tgt;
    n = 0;
    acc_cyc = -1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!in_ready) begin
      fails++;
      $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
    end else begin
      acc_cyc = cyc;
      if (exp_ok) begin
        x.a = exp_addr; x.d = exp_word;
        sb.push_back(x);
        exp_addr = exp_addr + 10'd1;
      end
      $display("[TB] accept op=%0d cycle=%0d", op, cyc);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s_done done=%b required=1", name, done);
    end else begin
      tests++;
      if (cpu_hold !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL %s_idle cpu_hold=%b busy=%b required 0 0", name, cpu_hold, busy);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({mem_we, in_ready, busy, done, err, cpu_hold} !== 6'b0 || err_index !== 11'd0) begin
      fails++;
      $display("FAIL reset_outputs we=%b rdy=%b busy=%b done=%b err=%b hold=%b idx=%0d required all 0",
               mem_we, in_ready, busy, done, err, cpu_hold, err_index);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({mem_we, busy, done, cpu_hold} !== 4'b0) begin
      fails++;
      $display("FAIL after_reset we=%b busy=%b done=%b hold=%b required 0", mem_we, busy, done, cpu_hold);
    end
    @(posedge clk); #1;
    $display("[TB] reset checked");
  endtask

  task automatic test_single();
    int a, w0, d0;
    w0 = writes; d0 = done_count;
    mem_ack = 1'b1;
    do_start(10'h010, 11'd1);
    send(5'd17, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0005, 26'd0, 1'b1, 32'h20220005, a);
    wait_done("single");
    tests++;
    if (writes - w0 != 1 || done_count - d0 != 1) begin
      fails++;
      $display("FAIL single_counts writes=%0d dones=%0d required 1 1", writes - w0, done_count - d0);
    end
  endtask

  task automatic test_back_to_back();
    int c1, c2, c3, w0;
    w0 = writes;
    mem_ack = 1'b1;
    do_start(10'h040, 11'd3);
    send(5'd7,  5'd1,  5'd2, 5'd3, 5'd0, 16'h0000, 26'd0,        1'b1, 32'h00221820, c1);
    send(5'd24, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'd0,        1'b1, 32'h8FA80004, c2);
    send(5'd27, 5'd0,  5'd0, 5'd0, 5'd0, 16'h0000, 26'h0100000,  1'b1, 32'h0C100000, c3);
    wait_done("b2b");
    tests++;
    if (c2 != c1 + 1 || c3 != c2 + 1) begin
      fails++;
      $display("FAIL b2b_throughput accept cycles %0d %0d %0d required consecutive", c1, c2, c3);
    end
    tests++;
    if (writes - w0 != 3) begin
      fails++;
      $display("FAIL b2b_writes count=%0d required 3", writes - w0);
    end
  endtask

  task automatic test_stall();
    int a;
    logic [9:0]  ha;
    logic [31:0] hd;
    mem_ack = 1'b0;
    do_start(10'h020, 11'd2);
    send(5'd0, 5'd7, 5'd5, 5'd4, 5'd2, 16'hFFFF, 26'h3FFFFFF, 1'b1, 32'h00052080, a);
    @(negedge clk);
    ha = mem_addr; hd = mem_wdata;
    tests++;
    if (mem_we !== 1'b1 || hd !== 32'h00052080 || ha !== 10'h020) begin
      fails++;
      $display("FAIL stall_first we=%b addr=%h data=%h required 1 020 00052080", mem_we, ha, hd);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (mem_we !== 1'b1 || mem_addr !== ha || mem_wdata !== hd || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold we=%b addr=%h data=%h rdy=%b required 1 %h %h 0",
                 mem_we, mem_addr, mem_wdata, in_ready, ha, hd);
      end
    end
    @(posedge clk); #1;
    mem_ack = 1'b1;
    send(5'd1, 5'd9, 5'd2, 5'd1, 5'd3, 16'h0000, 26'd0, 1'b1, 32'h000208C2, a);
    wait_done("stall");
  endtask

  task automatic test_wrap();
    int a;
    mem_ack = 1'b1;
    do_start(10'h3FF, 11'd2);
    send(5'd21, 5'd3, 5'd4, 5'd0, 5'd0, 16'h00FF, 26'd0, 1'b1, 32'h346400FF, a);
    send(5'd23, 5'd5, 5'd6, 5'd0, 5'd0, 16'h1234, 26'd0, 1'b1, 32'h3C061234, a);
    wait_done("wrap");
  endtask

  task automatic test_error();
    int a, n, w0, d0;
    w0 = writes; d0 = done_count;
    mem_ack = 1'b1;
    do_start(10'h100, 11'd4);
    send(5'd9,  5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'd0,       1'b1, 32'h00221824, a);
    send(5'd26, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0000, 26'h0000ABC, 1'b1, 32'h08000ABC, a);
    send(5'd30, 5'd1, 5'd1, 5'd1, 5'd1, 16'h1111, 26'd0,       1'b0, 32'h0, a);
    n = 0;
    @(negedge clk);
    while ((busy || !cpu_hold) && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (err !== 1'b1 || err_index !== 11'd2 || cpu_hold !== 1'b1 || busy !== 1'b0 ||
        mem_we !== 1'b0 || in_ready !== 1'b0) begin
      fails++;
      $display("FAIL error_state err=%b idx=%0d hold=%b busy=%b we=%b rdy=%b required 1 2 1 0 0 0",
               err, err_index, cpu_hold, busy, mem_we, in_ready);
    end
    tests++;
    if (writes - w0 != 2 || done_count != d0) begin
      fails++;
      $display("FAIL error_drain writes=%0d dones=%0d required 2 0", writes - w0, done_count - d0);
    end
    @(posedge clk); #1;
    do_start(10'h200, 11'd1);
    @(negedge clk);
    tests++;
    if (err !== 1'b0 || err_index !== 11'd0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL error_clear err=%b idx=%0d busy=%b required 0 0 1", err, err_index, busy);
    end
    @(posedge clk); #1;
    send(5'd15, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'd0, 1'b1, 32'h1022FFFF, a);
    wait_done("recover");
  endtask

  task automatic test_reset_mid();
    int a, w0, d0;
    mem_ack = 1'b0;
    do_start(10'h080, 11'd2);
    send(5'd10, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0000, 26'd0, 1'b1, 32'h00221825, a);
    @(negedge clk);
    tests++;
    if (mem_we !== 1'b1) begin
      fails++;
      $display("FAIL midreset_pre we=%b required 1", mem_we);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (mem_we !== 1'b0 || busy !== 1'b0 || cpu_hold !== 1'b0) begin
      fails++;
      $display("FAIL midreset_async we=%b busy=%b hold=%b required 0 0 0", mem_we, busy, cpu_hold);
    end
    sb.delete();
    $display("[TB] asynchronous reset applied mid-load");
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ack = 1'b1;
    @(posedge clk); #1;
    w0 = writes; d0 = done_count;
    do_start(10'h000, 11'd0);
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL zero_count_done done=%b busy=%b required 1 0", done, busy);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || writes != w0 || mem_we !== 1'b0) begin
      fails++;
      $display("FAIL zero_count_after done=%b writes=%0d we=%b required 0 0 0", done, writes - w0, mem_we);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_wrap();
    test_error();
    test_reset_mid();
    repeat (3) @(posedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_leftover entries=%0d required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
